stream_idle_demux: RTL and testbench

STREAM_IDLE_DEMUX -- requirements
Module: stream_idle_demux

---
 rtl/stream_idle_demux_pkg.sv | 44 ++++
 rtl/stream_idle_demux_if.sv | 42 ++++
 rtl/stream_idle_demux_bs_timer.sv | 58 +++++
 rtl/stream_idle_demux.sv | 186 ++++++++++++++++++
 tb/tb_stream_idle_demux.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_idle_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_idle_demux_pkg
//  Description : Shared constants for the main-link stream demux: control
//                symbol codes, region_sel encodings (common with the
//                source-side stream mux), FSM state enum and timer width.
//  Revision    : 1.0  initial release
// ============================================================================
package stream_idle_demux_pkg;

  // Control (K) symbol codes
  localparam logic [7:0] K_BS = 8'hBC;  // blanking start
  localparam logic [7:0] K_BE = 8'hFB;  // blanking end
  localparam logic [7:0] K_SR = 8'h1C;  // scrambler reset (acts like BS)
  localparam logic [7:0] K_FS = 8'hFE;  // fill start
  localparam logic [7:0] K_FE = 8'hF7;  // fill end

  // region_sel encodings
  localparam logic [1:0] REGION_ACTIVE = 2'b10;
  localparam logic [1:0] REGION_BLANK  = 2'b01;
  localparam logic [1:0] REGION_IDLE   = 2'b00;

  // Width of the BS/SR timeout counter
  localparam int TMR_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_BLANK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FILL   = 3'd4
  } demux_state_e;

  // Region reported for a symbol classified in a given state
  function automatic logic [1:0] region_of(input demux_state_e st);
    case (st)
      ST_ACTIVE, ST_FILL: region_of = REGION_ACTIVE;
      ST_HDR, ST_BLANK:   region_of = REGION_BLANK;
      default:            region_of = REGION_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_idle_demux_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_idle_demux_if
//  Description : Symbol input and demultiplexed output bundle of the
//                stream_idle_demux. The slave modport is the demux itself,
//                the master modport is whoever feeds and observes it.
//  Revision    : 1.0  initial release
// ============================================================================
interface stream_idle_demux_if;
  logic [7:0] in_symbols;
  logic       in_control_sym_flag;
  logic       in_valid;

  logic [7:0] active_symbols;
  logic       active_valid;
  logic [7:0] blank_symbols;
  logic       blank_control_sym_flag;
  logic       blank_valid;
  logic       idle_valid;
  logic [1:0] region_sel;
  logic [7:0] vbid;
  logic [7:0] mvid;
  logic [7:0] maud;
  logic       hdr_valid;
  logic       sym_err;
  logic       sync_lost;

  modport slave (
    input  in_symbols, in_control_sym_flag, in_valid,
    output active_symbols, active_valid, blank_symbols, blank_control_sym_flag,
           blank_valid, idle_valid, region_sel, vbid, mvid, maud, hdr_valid,
           sym_err, sync_lost
  );

  modport master (
    output in_symbols, in_control_sym_flag, in_valid,
    input  active_symbols, active_valid, blank_symbols, blank_control_sym_flag,
           blank_valid, idle_valid, region_sel, vbid, mvid, maud, hdr_valid,
           sym_err, sync_lost
  );
endinterface
`default_nettype wire

// File: rtl/stream_idle_demux_bs_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_bs_timer
//  Description : Counts valid symbols since the last BS/SR. expire_o flags
//                (combinationally) the symbol that reaches BS_TIMEOUT;
//                sync_lost_o is the registered one-cycle pulse aligned with
//                the demux outputs. The count holds at BS_TIMEOUT until the
//                next BS/SR so the pulse fires only once per loss.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_bs_timer
  import stream_idle_demux_pkg::*;
#(
  parameter int BS_TIMEOUT = 8192
) (
  input  logic clk,
  input  logic rst_n,       // active-high asynchronous reset
  input  logic restart_i,   // valid BS/SR seen
  input  logic inc_i,       // valid symbol that counts toward the timeout
  output logic expire_o,
  output logic sync_lost_o
);

  localparam logic [TMR_W-1:0] LIMIT    = BS_TIMEOUT[TMR_W-1:0];
  localparam int               LIMIT_I1 = BS_TIMEOUT - 1;
  localparam logic [TMR_W-1:0] LIMIT_M1 = LIMIT_I1[TMR_W-1:0];

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;
  logic             sync_lost_q;

  // Next count: restart on BS/SR, otherwise saturate at the limit
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < LIMIT)) begin
      cnt_d    = cnt_q + TMR_W'(1);
      expire_o = (cnt_q == LIMIT_M1);
    end
  end

  // Count register and registered loss pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q       <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sync_lost_q <= expire_o;
    end
  end

  assign sync_lost_o = sync_lost_q;

endmodule
`default_nettype wire

// File: rtl/stream_idle_demux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_idle_demux
//  Description : Splits a one-lane post-descramble main-link symbol stream
//                into active (pixel), blanking and idle paths, captures the
//                VB-ID/Mvid/Maud header after each BS/SR, flags illegal
//                control symbols and detects loss of BS cadence.
//                Every output is registered, one clock after its symbol.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_idle_demux
  import stream_idle_demux_pkg::*;
#(
  parameter int BS_TIMEOUT = 8192
) (
  input  logic                 clk,
  input  logic                 rst_n,   // active-high asynchronous reset
  stream_idle_demux_if.slave   bus
);

  demux_state_e state_q;
  logic [1:0]   hdr_idx_q;
  logic [7:0]   hdr0_q;       // header bytes held until all three arrive
  logic [7:0]   hdr1_q;
  logic [7:0]   active_sym_q;
  logic         active_valid_q;
  logic [7:0]   blank_sym_q;
  logic         blank_flag_q;
  logic         blank_valid_q;
  logic         idle_valid_q;
  logic [1:0]   region_q;
  logic [7:0]   vbid_q;
  logic [7:0]   mvid_q;
  logic [7:0]   maud_q;
  logic         hdr_valid_q;
  logic         sym_err_q;

  logic [7:0]   w_sym;
  logic         w_k;
  logic         w_bs_sr;
  logic         w_inc;
  logic         w_expire;
  logic         w_sync_lost;

  // Input decode: BS/SR restart, and which symbols age the timer
  always_comb begin
    w_sym   = bus.in_symbols;
    w_k     = bus.in_control_sym_flag;
    w_bs_sr = bus.in_valid && w_k && ((w_sym == K_BS) || (w_sym == K_SR));
    // Header bytes belong to the BS sequence and do not age the timer
    w_inc   = bus.in_valid && !w_bs_sr && (state_q != ST_HDR);
  end

  stream_bs_timer #(
    .BS_TIMEOUT (BS_TIMEOUT)
  ) u_bs_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (w_bs_sr),
    .inc_i       (w_inc),
    .expire_o    (w_expire),
    .sync_lost_o (w_sync_lost)
  );

  // Region FSM with registered path outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= ST_IDLE;
      hdr_idx_q      <= 2'd0;
      hdr0_q         <= 8'h00;
      hdr1_q         <= 8'h00;
      active_sym_q   <= 8'h00;
      active_valid_q <= 1'b0;
      blank_sym_q    <= 8'h00;
      blank_flag_q   <= 1'b0;
      blank_valid_q  <= 1'b0;
      idle_valid_q   <= 1'b0;
      region_q       <= REGION_IDLE;
      vbid_q         <= 8'h00;
      mvid_q         <= 8'h00;
      maud_q         <= 8'h00;
      hdr_valid_q    <= 1'b0;
      sym_err_q      <= 1'b0;
    end else begin
      active_valid_q <= 1'b0;
      blank_valid_q  <= 1'b0;
      idle_valid_q   <= 1'b0;
      hdr_valid_q    <= 1'b0;
      sym_err_q      <= 1'b0;
      region_q       <= region_of(state_q);

      if (bus.in_valid) begin
        if (w_bs_sr) begin
          // BS/SR restarts framing from any state
          state_q       <= ST_HDR;
          hdr_idx_q     <= 2'd0;
          blank_valid_q <= 1'b1;
          blank_sym_q   <= w_sym;
          blank_flag_q  <= 1'b1;
        end else if (w_expire) begin
          // Cadence lost: this symbol is already treated as idle
          state_q      <= ST_IDLE;
          idle_valid_q <= 1'b1;
          region_q     <= REGION_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (w_k) sym_err_q    <= 1'b1;
              else     idle_valid_q <= 1'b1;
            end

            ST_HDR: begin
              if (w_k) begin
                // Broken header: keep the previous fields
                sym_err_q <= 1'b1;
                state_q   <= ST_BLANK;
              end else begin
                hdr_idx_q <= hdr_idx_q + 2'd1;
                case (hdr_idx_q)
                  2'd0:    hdr0_q <= w_sym;
                  2'd1:    hdr1_q <= w_sym;
                  default: begin
                    vbid_q      <= hdr0_q;
                    mvid_q      <= hdr1_q;
                    maud_q      <= w_sym;
                    hdr_valid_q <= 1'b1;
                    // VB-ID bit 3 = NoVideoStream
                    state_q     <= hdr0_q[3] ? ST_IDLE : ST_BLANK;
                  end
                endcase
              end
            end

            ST_BLANK: begin
              if (!w_k || (w_sym == K_BE)) begin
                blank_valid_q <= 1'b1;
                blank_sym_q   <= w_sym;
                blank_flag_q  <= w_k;
                if (w_k) state_q <= ST_ACTIVE;
              end else begin
                sym_err_q <= 1'b1;
              end
            end

            ST_ACTIVE: begin
              if (!w_k) begin
                active_valid_q <= 1'b1;
                active_sym_q   <= w_sym;
              end else if (w_sym == K_FS) begin
                state_q <= ST_FILL;
              end else if (w_sym != K_FE) begin
                sym_err_q <= 1'b1;
              end
            end

            ST_FILL: begin
              // Fill content is dropped silently
              if (w_k) begin
                if (w_sym == K_FE)      state_q   <= ST_ACTIVE;
                else if (w_sym != K_FS) sym_err_q <= 1'b1;
              end
            end

            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.active_symbols         = active_sym_q;
  assign bus.active_valid           = active_valid_q;
  assign bus.blank_symbols          = blank_sym_q;
  assign bus.blank_control_sym_flag = blank_flag_q;
  assign bus.blank_valid            = blank_valid_q;
  assign bus.idle_valid             = idle_valid_q;
  assign bus.region_sel             = region_q;
  assign bus.vbid                   = vbid_q;
  assign bus.mvid                   = mvid_q;
  assign bus.maud                   = maud_q;
  assign bus.hdr_valid              = hdr_valid_q;
  assign bus.sym_err                = sym_err_q;
  assign bus.sync_lost              = w_sync_lost;

endmodule
`default_nettype wire

// File: tb/tb_stream_idle_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_idle_demux
//  Description : Drives two demux instances (default timeout and a 16-symbol
//                timeout) with the same symbol stream and compares every
//                output after every clock against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stream_idle_demux;
  import stream_idle_demux_pkg::*;

  localparam int TO_A = 8192;
  localparam int TO_B = 16;
  localparam int M_IDLE = 0, M_HDR = 1, M_BLANK = 2, M_ACTIVE = 3, M_FILL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_idle_demux_if bus_a ();
  stream_idle_demux_if bus_b ();

  stream_idle_demux #(.BS_TIMEOUT(TO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  stream_idle_demux #(.BS_TIMEOUT(TO_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic [7:0] as; logic av; logic [7:0] bs; logic bf; logic bv; logic iv;
    logic [1:0] rg; logic [7:0] vb; logic [7:0] mv; logic [7:0] ma;
    logic hv; logic er; logic sl;
  } exp_t;

  exp_t       ex [2];
  int         mode [2];
  int         since [2];
  logic [7:0] hq [2][$];
  int         tmo [2];

  int checks = 0;
  int errors = 0;
  int n_av [2], n_bv [2], n_iv [2], n_hv [2], n_er [2], n_sl [2];
  int rnd;

  function automatic logic [1:0] mode_region(input int m);
    if (m == M_ACTIVE || m == M_FILL) return 2'b10;
    if (m == M_HDR || m == M_BLANK)   return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ex[d] = '{default: '0};
      mode[d] = M_IDLE;
      since[d] = 0;
      hq[d].delete();
    end
  endtask

  // Behavioural expectation for one clock of one instance
  task automatic model_step(input int d, input logic v, input logic [7:0] s, input logic k);
    ex[d].av = 0; ex[d].bv = 0; ex[d].iv = 0; ex[d].hv = 0; ex[d].er = 0; ex[d].sl = 0;
    ex[d].rg = mode_region(mode[d]);
    if (!v) return;
    if (k && (s == K_BS || s == K_SR)) begin
      mode[d] = M_HDR; hq[d].delete(); since[d] = 0;
      ex[d].bv = 1; ex[d].bs = s; ex[d].bf = 1;
      return;
    end
    if (mode[d] != M_HDR) begin
      since[d]++;
      if (since[d] == tmo[d]) begin
        mode[d] = M_IDLE; ex[d].iv = 1; ex[d].sl = 1; ex[d].rg = 2'b00;
        return;
      end
    end
    case (mode[d])
      M_IDLE:  if (k) ex[d].er = 1; else ex[d].iv = 1;
      M_HDR: begin
        if (k) begin ex[d].er = 1; mode[d] = M_BLANK; end
        else begin
          hq[d].push_back(s);
          if (hq[d].size() == 3) begin
            ex[d].vb = hq[d][0]; ex[d].mv = hq[d][1]; ex[d].ma = hq[d][2]; ex[d].hv = 1;
            mode[d] = hq[d][0][3] ? M_IDLE : M_BLANK;
          end
        end
      end
      M_BLANK: begin
        if (!k || s == K_BE) begin
          ex[d].bv = 1; ex[d].bs = s; ex[d].bf = k;
          if (k) mode[d] = M_ACTIVE;
        end else ex[d].er = 1;
      end
      M_ACTIVE: begin
        if (!k) begin ex[d].av = 1; ex[d].as = s; end
        else if (s == K_FS) mode[d] = M_FILL;
        else if (s != K_FE) ex[d].er = 1;
      end
      default: begin
        if (k && s == K_FE) mode[d] = M_ACTIVE;
        else if (k && s != K_FS) ex[d].er = 1;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] as, input logic av,
                           input logic [7:0] bs, input logic bf, input logic bv,
                           input logic iv, input logic [1:0] rg, input logic [7:0] vb,
                           input logic [7:0] mv, input logic [7:0] ma,
                           input logic hv, input logic er, input logic sl);
    string p;
    p = (d == 0) ? "a" : "b";
    chk({p, ".active_valid"}, 32'(av), 32'(ex[d].av));
    chk({p, ".active_symbols"}, 32'(as), 32'(ex[d].as));
    chk({p, ".blank_valid"}, 32'(bv), 32'(ex[d].bv));
    chk({p, ".blank_symbols"}, 32'(bs), 32'(ex[d].bs));
    chk({p, ".blank_flag"}, 32'(bf), 32'(ex[d].bf));
    chk({p, ".idle_valid"}, 32'(iv), 32'(ex[d].iv));
    chk({p, ".region_sel"}, 32'(rg), 32'(ex[d].rg));
    chk({p, ".vbid"}, 32'(vb), 32'(ex[d].vb));
    chk({p, ".mvid"}, 32'(mv), 32'(ex[d].mv));
    chk({p, ".maud"}, 32'(ma), 32'(ex[d].ma));
    chk({p, ".hdr_valid"}, 32'(hv), 32'(ex[d].hv));
    chk({p, ".sym_err"}, 32'(er), 32'(ex[d].er));
    chk({p, ".sync_lost"}, 32'(sl), 32'(ex[d].sl));
    n_av[d] += int'(av); n_bv[d] += int'(bv); n_iv[d] += int'(iv);
    n_hv[d] += int'(hv); n_er[d] += int'(er); n_sl[d] += int'(sl);
  endtask

  task automatic check_all();
    check_dut(0, bus_a.active_symbols, bus_a.active_valid, bus_a.blank_symbols,
              bus_a.blank_control_sym_flag, bus_a.blank_valid, bus_a.idle_valid,
              bus_a.region_sel, bus_a.vbid, bus_a.mvid, bus_a.maud,
              bus_a.hdr_valid, bus_a.sym_err, bus_a.sync_lost);
    check_dut(1, bus_b.active_symbols, bus_b.active_valid, bus_b.blank_symbols,
              bus_b.blank_control_sym_flag, bus_b.blank_valid, bus_b.idle_valid,
              bus_b.region_sel, bus_b.vbid, bus_b.mvid, bus_b.maud,
              bus_b.hdr_valid, bus_b.sym_err, bus_b.sync_lost);
  endtask

  task automatic clr_tally();
    for (int d = 0; d < 2; d++) begin
      n_av[d] = 0; n_bv[d] = 0; n_iv[d] = 0; n_hv[d] = 0; n_er[d] = 0; n_sl[d] = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic k);
    bus_a.in_valid = v; bus_a.in_symbols = s; bus_a.in_control_sym_flag = k;
    bus_b.in_valid = v; bus_b.in_symbols = s; bus_b.in_control_sym_flag = k;
  endtask

  task automatic send(input logic v, input logic [7:0] s, input logic k);
    @(negedge clk);
    drive(v, s, k);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d, v, s, k);
    check_all();
  endtask

  task automatic data(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 8'($urandom), 1'b0);
  endtask

  task automatic header(input logic [7:0] vb, input logic [7:0] mv, input logic [7:0] ma);
    send(1'b1, K_BS, 1'b1);
    send(1'b1, vb, 1'b0);
    send(1'b1, mv, 1'b0);
    send(1'b1, ma, 1'b0);
  endtask

  initial begin
    tmo[0] = TO_A;
    tmo[1] = TO_B;
    drive(1'b0, 8'h00, 1'b0);
    clr_tally();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;

    // Header, 20 blanking symbols, BE, 10 active symbols
    clr_tally();
    header(8'h00, 8'h12, 8'h34);
    chk("a.hdr_count", 32'(n_hv[0]), 32'd1);
    clr_tally();
    data(20);
    chk("a.blank_count", 32'(n_bv[0]), 32'd20);
    chk("b.sync_lost_in_blank", 32'(n_sl[1]), 32'd1);
    send(1'b1, K_BE, 1'b1);
    clr_tally();
    data(10);
    chk("a.active_count10", 32'(n_av[0]), 32'd10);

    // Fill inside active, with a bubble
    clr_tally();
    data(4);
    send(1'b1, K_FS, 1'b1);
    data(2);
    send(1'b0, 8'h55, 1'b0);
    data(1);
    send(1'b1, K_FE, 1'b1);
    data(2);
    chk("a.active_count_fill", 32'(n_av[0]), 32'd6);

    // NoVideoStream header
    header(8'h08, 8'hAA, 8'hBB);
    clr_tally();
    data(3);
    chk("a.novideo_idle", 32'(n_iv[0]), 32'd3);
    chk("a.novideo_paths", 32'(n_av[0] + n_bv[0]), 32'd0);

    // Illegal control symbols: BE in idle, FE in blanking
    clr_tally();
    send(1'b1, K_BE, 1'b1);
    chk("a.be_idle_err", 32'(n_er[0]), 32'd1);
    header(8'h00, 8'h01, 8'h02);
    clr_tally();
    send(1'b1, K_FE, 1'b1);
    data(1);
    chk("a.fe_blank_err", 32'(n_er[0]), 32'd1);
    chk("a.fe_blank_stays", 32'(n_bv[0]), 32'd1);

    // Timeout on the 16-symbol instance, then recovery
    header(8'h00, 8'h01, 8'h02);
    clr_tally();
    data(17);
    chk("b.sync_lost_once", 32'(n_sl[1]), 32'd1);
    header(8'h00, 8'h03, 8'h04);
    clr_tally();
    data(2);
    chk("b.recovered_blank", 32'(n_bv[1]), 32'd2);

    // Randomised symbol mix
    for (int n = 0; n < 400; n++) begin
      rnd = int'($urandom_range(0, 99));
      if (rnd < 10)      send(1'b0, 8'($urandom), 1'($urandom));
      else if (rnd < 63) send(1'b1, 8'($urandom), 1'b0);
      else if (rnd < 67) send(1'b1, K_BS, 1'b1);
      else if (rnd < 69) send(1'b1, K_SR, 1'b1);
      else if (rnd < 77) send(1'b1, K_BE, 1'b1);
      else if (rnd < 85) send(1'b1, K_FS, 1'b1);
      else if (rnd < 93) send(1'b1, K_FE, 1'b1);
      else               send(1'b1, 8'h7C, 1'b1);
    end

    // Asynchronous reset while active with in_valid high
    header(8'h00, 8'h05, 8'h06);
    send(1'b1, K_BE, 1'b1);
    data(3);
    @(negedge clk);
    drive(1'b1, 8'h77, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b0;
    clr_tally();
    data(3);
    chk("a.post_reset_idle", 32'(n_iv[0]), 32'd3);
    chk("a.post_reset_paths", 32'(n_av[0] + n_bv[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
